// File: rtl/debug_pkg.sv
// Shared constants and types for the UART debug sequencer and its byte sender.
package debug_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_DUMP = 8'h64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    DUMP
  } state_t;

  localparam int WORD_PC   = 0;
  localparam int WORD_CYC  = 1;
  localparam int WORD_REG0 = 2;

  // Number of 32-bit words in one state dump: PC, cycle count, then registers.
  function automatic int dump_words(input int regs);
    return WORD_REG0 + regs;
  endfunction

endpackage

// File: rtl/word_byte_sender.sv
// Serialises one 32-bit word into four UART bytes, MSB first, honouring the
// tx_start/tx_busy handshake with a one-cycle guard after every start.
module word_byte_sender (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  output logic        o_done
);

  logic [31:0] r_word;
  logic [2:0]  r_sent;
  logic        r_active;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;
  logic        r_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_word     <= '0;
      r_sent     <= '0;
      r_active   <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      if (i_load) begin
        r_word   <= i_word;
        r_sent   <= '0;
        r_active <= 1'b1;
      end else if (r_active && !r_tx_start && !i_tx_busy) begin
        // A high r_tx_start marks the guard cycle: the UART has not yet
        // raised busy, so its level cannot be trusted there.
        if (r_sent == 3'd4) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end else begin
          r_tx_start <= 1'b1;
          r_tx_data  <= r_word[31:24];
          r_word     <= {r_word[23:0], 8'h00};
          r_sent     <= r_sent + 3'd1;
        end
      end
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_done     = r_done;

endmodule

// File: rtl/debug_step_controller.sv
// Host-command debug sequencer: run/step gating of the pipeline enable and
// a PC / cycle-count / register-file dump streamed out through the UART.
module debug_step_controller
  import debug_pkg::*;
#(
  parameter int DUMP_REGS = 32,
  parameter int CYCLE_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        cpu_en,
  input  logic        cpu_halt,
  input  logic [31:0] pc_in,
  output logic [4:0]  dump_addr,
  input  logic [31:0] dump_data,
  output logic        halted
);

  localparam int         N_WORDS  = dump_words(DUMP_REGS);
  localparam logic [5:0] END_IDX  = 6'(N_WORDS);
  localparam logic [5:0] LAST_IDX = 6'(N_WORDS - 1);

  state_t             r_state;
  logic [CYCLE_W-1:0] r_cyc;
  logic [31:0]        r_cyc_snap;
  logic               r_halted;
  logic [5:0]         r_word_idx;
  logic               r_load_pending;
  logic [4:0]         r_dump_addr;

  logic        w_load;
  logic [31:0] w_word;
  logic        w_done;

  // The enable must drop in the very cycle halt is seen, so it is decoded
  // from state rather than registered.
  assign cpu_en = ((r_state == RUN) && !cpu_halt) || (r_state == STEP);
  assign w_load = (r_state == DUMP) && r_load_pending;

  // NOTE: default assignment first so no path leaves w_word unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_word = dump_data;
    if (r_word_idx == 6'(WORD_PC))
      w_word = pc_in;
    else if (r_word_idx == 6'(WORD_CYC))
      w_word = r_cyc_snap;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_cyc          <= '0;
      r_cyc_snap     <= '0;
      r_halted       <= 1'b0;
      r_word_idx     <= '0;
      r_load_pending <= 1'b0;
      r_dump_addr    <= '0;
    end else begin
      if (cpu_en)
        r_cyc <= r_cyc + CYCLE_W'(1);

      case (r_state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_RUN && !r_halted) begin
              r_state <= RUN;
            end else if (rx_data == CMD_STEP && !r_halted) begin
              r_state <= STEP;
            end else if (rx_data == CMD_DUMP) begin
              r_state        <= DUMP;
              r_word_idx     <= '0;
              r_load_pending <= 1'b1;
            end
          end
        end

        RUN: begin
          if (cpu_halt) begin
            r_halted       <= 1'b1;
            r_state        <= DUMP;
            r_word_idx     <= '0;
            r_load_pending <= 1'b1;
          end
        end

        STEP: begin
          if (cpu_halt)
            r_halted <= 1'b1;
          r_state        <= DUMP;
          r_word_idx     <= '0;
          r_load_pending <= 1'b1;
        end

        DUMP: begin
          if (w_load) begin
            r_load_pending <= 1'b0;
            r_word_idx     <= r_word_idx + 6'd1;
            if (r_word_idx == 6'(WORD_PC))
              r_cyc_snap <= 32'(r_cyc);
            // Pre-drive the address for the next word so dump_data is
            // settled in the cycle that word is loaded.
            if (r_word_idx >= 6'(WORD_CYC) && r_word_idx != LAST_IDX)
              r_dump_addr <= 5'(r_word_idx - 6'd1);
          end else if (w_done) begin
            if (r_word_idx == END_IDX) begin
              r_state     <= IDLE;
              r_dump_addr <= '0;
            end else begin
              r_load_pending <= 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  word_byte_sender u_sender (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_word     (w_word),
    .i_tx_busy  (tx_busy),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .o_done     (w_done)
  );

  assign dump_addr = r_dump_addr;
  assign halted    = r_halted;

endmodule

// File: tb/tb_debug_step_controller.sv
// Scoreboard bench: stimulus queues expected dump bytes from a word-level model,
// a negedge monitor pops and compares each byte the DUT transmits.
module tb_debug_step_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        cpu_en;
  logic        cpu_halt = 1'b0;
  logic [31:0] pc_in = '0;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        halted;

  localparam int NREGS = 32;
  localparam int DUMP_BYTES = 4 * (2 + NREGS);

  debug_step_controller #(.DUMP_REGS(NREGS), .CYCLE_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .cpu_en    (cpu_en),
    .cpu_halt  (cpu_halt),
    .pc_in     (pc_in),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [NREGS];
  assign dump_data = rf[dump_addr];

  int n_vec = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rx_log [$];
  int busy_len = 2;
  int busy_cnt = 0;
  bit start_pending = 1'b0;
  int tx_count = 0;
  int en_total = 0;
  logic [31:0] model_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every transmitted byte against the scoreboard queue.
  always @(negedge clk) begin
    if (cpu_en === 1'b1) en_total++;
    if (tx_start === 1'b1) begin
      tx_count++;
      rx_log.push_back(tx_data);
      start_pending = 1'b1;
      check("no_start_while_busy", 32'(tx_busy), 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL tx_unexpected: got byte %h expected no transmission", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // UART model: busy rises the cycle after tx_start and holds for busy_len cycles.
  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      busy_cnt = 0;
      start_pending = 1'b0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      if (start_pending) begin
        busy_cnt = busy_len;
        start_pending = 1'b0;
      end
    end
    tx_busy = (busy_cnt > 0);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    rx_valid = 1'b0;
    cpu_halt = 1'b0;
    exp_q.delete();
    cyc(n);
    exp_q.delete();
    model_cyc = 0;
    reset = 1'b1;
  endtask

  task automatic send(input logic [7:0] c);
    rx_data = c;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cnt);
    rx_log.delete();
    push_word(pc);
    push_word(cnt);
    for (int r = 0; r < NREGS; r++) push_word(rf[r]);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      cyc(1);
      t++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    cyc(busy_len + 6);
    check({name, "_addr_idle"}, 32'(dump_addr), 32'd0);
    check({name, "_len"}, 32'(rx_log.size()), 32'(DUMP_BYTES));
  endtask

  task automatic randomize_rf();
    for (int r = 0; r < NREGS; r++) rf[r] = $urandom();
    rf[3] = 32'hDEADBEEF;
  endtask

  initial begin
    int en0, tx0, n, g;
    logic [7:0] b;
    logic [7:0] hdr [8];
    logic [7:0] dead [4];

    randomize_rf();

    // Reset, then silence without commands.
    do_reset(3);
    @(negedge clk);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_dump_addr", 32'(dump_addr), 32'd0);
    en0 = en_total;
    tx0 = tx_count;
    cyc(50);
    check("idle_no_en", 32'(en_total - en0), 32'd0);
    check("idle_no_tx", 32'(tx_count - tx0), 32'd0);

    // Single step.
    do_reset(2);
    pc_in = 32'h0000_0004;
    en0 = en_total;
    model_cyc = model_cyc + 1;
    push_dump(pc_in, model_cyc);
    send(8'h73);
    wait_drain("step_dump", 4000);
    check("step_en_once", 32'(en_total - en0), 32'd1);
    hdr = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 8; i++) check("step_hdr", 32'(rx_log[i]), 32'(hdr[i]));

    // Slow UART dump with commands dropped mid-stream.
    busy_len = 20;
    pc_in = $urandom();
    en0 = en_total;
    tx0 = tx_count;
    push_dump(pc_in, model_cyc);
    send(8'h64);
    g = 0;
    while (tx_count - tx0 < 3 && g < 500) begin cyc(1); g++; end
    send(8'h73);
    cyc(5);
    send(8'h41);
    wait_drain("slow_dump", 136 * 30);
    check("slow_no_en", 32'(en_total - en0), 32'd0);
    dead = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 4; i++) check("slow_reg3", 32'(rx_log[20 + i]), 32'(dead[i]));
    busy_len = 2;

    // Randomised command sequence against the model.
    for (int it = 0; it < 12; it++) begin
      busy_len = $urandom_range(1, 5);
      pc_in = $urandom();
      randomize_rf();
      en0 = en_total;
      tx0 = tx_count;
      case ($urandom_range(0, 2))
        0: begin
          model_cyc = model_cyc + 1;
          push_dump(pc_in, model_cyc);
          send(8'h73);
          wait_drain("rand_step", 4000);
          check("rand_step_en", 32'(en_total - en0), 32'd1);
        end
        1: begin
          push_dump(pc_in, model_cyc);
          send(8'h64);
          wait_drain("rand_dump", 4000);
          check("rand_dump_en", 32'(en_total - en0), 32'd0);
        end
        default: begin
          do b = 8'($urandom_range(0, 255));
          while (b == 8'h63 || b == 8'h73 || b == 8'h64);
          send(b);
          cyc(20);
          check("rand_junk_en", 32'(en_total - en0), 32'd0);
          check("rand_junk_tx", 32'(tx_count - tx0), 32'd0);
        end
      endcase
    end
    busy_len = 2;

    // Run until halt after ten enabled cycles.
    do_reset(2);
    pc_in = $urandom();
    send(8'h63);
    n = 0;
    g = 0;
    while (n < 10 && g < 200) begin
      @(negedge clk);
      if (cpu_en) n++;
      g++;
    end
    check("run_en_cycles", 32'(n), 32'd10);
    @(posedge clk);
    #1;
    cpu_halt = 1'b1;
    model_cyc = model_cyc + 10;
    push_dump(pc_in, model_cyc);
    @(negedge clk);
    check("run_halt_en", 32'(cpu_en), 32'd0);
    @(negedge clk);
    check("run_halted", 32'(halted), 32'd1);
    wait_drain("run_dump", 4000);
    hdr = '{8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) check("run_cycles", 32'(rx_log[4 + i]), 32'(hdr[i]));

    // Step is refused once halted.
    en0 = en_total;
    tx0 = tx_count;
    send(8'h73);
    cyc(30);
    check("halted_step_en", 32'(en_total - en0), 32'd0);
    check("halted_step_tx", 32'(tx_count - tx0), 32'd0);

    // Reset in the middle of a dump.
    tx0 = tx_count;
    push_dump(pc_in, model_cyc);
    send(8'h64);
    g = 0;
    while (tx_count - tx0 < 10 && g < 2000) begin @(negedge clk); g++; end
    check("mid_reached_10", 32'(tx_count - tx0), 32'd10);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cpu_halt = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_cpu_en", 32'(cpu_en), 32'd0);
    check("mid_rst_halted", 32'(halted), 32'd0);
    check("mid_rst_dump_addr", 32'(dump_addr), 32'd0);
    do_reset(2);
    tx0 = tx_count;
    cyc(40);
    check("mid_rst_silent", 32'(tx_count - tx0), 32'd0);
    pc_in = $urandom();
    push_dump(pc_in, 32'd0);
    send(8'h64);
    wait_drain("fresh_dump", 4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/debug_step_controller.md
Name: debug_step_controller

Overview:
- Debug sequencer between the UART byte interfaces (rx/tx) and the MIPS DataPath.
- Decodes single-byte host commands and gates the pipeline clock-enable for continuous run or single step.
- After each step, after a halt, or on request, streams a state dump back through the UART transmitter: PC, cycle count, then the register file.

Parameters:
- DUMP_REGS, 32: number of register-file entries dumped, from address 0 upward; range 1..32.
- CYCLE_W, 32: cycle-counter width; dumped as 4 bytes, zero-extended or truncated to 32 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- tx_data  out  8  byte to UART transmitter.
- tx_start  out  1  one-cycle strobe: transmit tx_data.
- tx_busy  in  1  UART transmitter busy; rises the cycle after tx_start.
- cpu_en  out  1  pipeline advance enable to DataPath.
- cpu_halt  in  1  DataPath has retired a halt instruction (level).
- pc_in  in  32  current PC from DataPath.
- dump_addr  out  5  register-file debug read address.
- dump_data  in  32  register-file debug read data, combinational from dump_addr.
- halted  out  1  sticky: program has halted.

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0, cycle counter 0, halted 0, state IDLE. Any in-progress run or dump is abandoned immediately with no further tx_start.
- Command codes: 0x63 'c' = run, 0x73 's' = step, 0x64 'd' = dump. Any other byte is ignored.
- Commands arriving in any state other than IDLE are dropped; there is no queueing.
- 'c' and 's' are ignored while halted==1. 'd' is always accepted in IDLE.
- IDLE: cpu_en=0. On rx_valid:
  - 'c' → RUN
  - 's' → STEP
  - 'd' → DUMP
- RUN: cpu_en=1 from the cycle after the 'c' strobe. Leave RUN in the first cycle cpu_halt==1 is sampled: cpu_en=0 that same cycle, halted set to 1, next state DUMP.
- STEP: 's' strobe in cycle t → cpu_en=1 in cycle t+1 only → DUMP entered at t+2. If cpu_halt==1 at t+1, halted is set.
- Cycle counter:
  - Increments by 1 on every cycle with cpu_en==1.
  - Wraps modulo 2^CYCLE_W.
  - Cleared only by reset.
- DUMP stream order is word by word, each word sent MSB byte first:
  1. PC, latched from pc_in on DUMP entry.
  2. Cycle count, latched on DUMP entry.
  3. Registers 0..DUMP_REGS-1. For each, dump_addr is driven and dump_data is captured in the same cycle the word is loaded.
  - Total bytes = 4*(2+DUMP_REGS); 136 at the default.
- Byte handshake:
  - tx_start is pulsed for one cycle only when tx_busy==0 and the controller is not in its guard cycle.
  - tx_data is held stable from the tx_start cycle until the next tx_start.
  - Guard cycle: the cycle after tx_start, tx_busy is ignored. After that, the controller waits for tx_busy==0 before the next tx_start.
  - Minimum spacing between tx_start pulses is 2 cycles.
- After the last byte's tx_start, and once tx_busy==0, the state returns to IDLE and dump_addr returns to 0.
- cpu_en is 0 throughout DUMP, so pipeline state is frozen while it is read.
- Simultaneous events: cpu_halt is ignored outside RUN and STEP. rx_valid while a tx is in progress is ignored.

Decomposition:
- Shared package (debug_pkg):
  - Command byte constants CMD_RUN, CMD_STEP, CMD_DUMP.
  - State enum IDLE/RUN/STEP/DUMP.
  - Dump word-index constants: WORD_PC=0, WORD_CYC=1, WORD_REG0=2.
- Sub-module word_byte_sender:
  - Loads a 32-bit word on a load strobe.
  - Emits 4 bytes MSB first using the tx_start/tx_busy handshake, including the guard cycle.
  - Raises done after the fourth byte completes.
- Top-level FSM owns the command decode, cycle counter, halted flag and word sequencing.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release. Expect cpu_en=0, tx_start=0, halted=0, and no activity for 50 cycles with no rx.
- Single step: reset, pc_in=0x00000004, send 0x73. Expect:
  - cpu_en high for exactly 1 cycle.
  - First 8 tx bytes are 00 00 00 04 00 00 00 01.
  - 136 bytes in total; dump_addr walks 0..31.
- Run to halt: send 0x63, assert cpu_halt after 10 cpu_en cycles. Expect cpu_en deasserted in that same cycle, halted=1, and cycle bytes 00 00 00 0A.
- Dump with slow UART: send 0x64, bench holds tx_busy high for 20 cycles after each start. Expect:
  - No tx_start while tx_busy==1.
  - Byte order preserved; register 3 = 0xDEADBEEF appears as DE AD BE EF at bytes 20..23.
- Ignored commands:
  - During a dump, send 0x73 and 0x41: the dump is unaffected and there are no extra cpu_en pulses.
  - After halted=1, send 0x73: cpu_en stays 0.
- Reset mid-dump: assert reset=0 after the 10th tx_start. Expect all outputs 0 next cycle and no further tx_start. A subsequent 0x64 yields a fresh 136-byte dump with cycle count 0.
